// File: rtl/cache_stats.sv
// Hit-rate monitor: counts accesses/hits over a window of ACCESS_LIMIT accesses, then divides to per-mille.
// Latency: rate_valid rises NUM_W cycles after window_done (one restoring-division step per cycle).
// Backpressure: result held with rate_valid until rate_ready; accesses arriving while busy or holding are dropped.
//
// Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    start                 synchronous clear, restarts the window from any state
//    access_valid, hit     one completed cache access per cycle, hit qualified by access_valid
//    access_count          accesses counted in the current window
//    hit_count             hits counted in the current window
//    miss_count            misses counted (only when CACHE_STATS_MISS_CNT_EN is defined)
//    window_done           window full (dividing or holding the result)
//    busy                  divider running
//    rate_valid/rate_ready result handshake
//    rate_permille         floor(hit_count*SCALE/access_count)
//
// Build option: define CACHE_STATS_MISS_CNT_EN to add the miss_count output and its counter.

module cache_stats #(
   parameter  int ACCESS_LIMIT = 8192,
   parameter  int SCALE        = 1000,
   localparam int CNT_W        = $clog2(ACCESS_LIMIT + 1),
   localparam int NUM_W        = CNT_W + 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             access_valid,
   input  logic             hit,
   output logic [CNT_W-1:0] access_count,
   output logic [CNT_W-1:0] hit_count,
`ifdef CACHE_STATS_MISS_CNT_EN
   output logic [CNT_W-1:0] miss_count,
`endif
   output logic             window_done,
   output logic             busy,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic [9:0]       rate_permille
);

   localparam int                ITER_W    = $clog2(NUM_W + 1);
   localparam logic [NUM_W-1:0]  SCALE_N   = NUM_W'(SCALE);
   localparam logic [CNT_W-1:0]  LIMIT_C   = CNT_W'(ACCESS_LIMIT);
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_W - 1);

   typedef enum logic [1:0] {COUNT, DIVIDE, HOLD} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    acc_inc, hit_inc;
   logic                last_access;

   // Divider: num shifts the dividend out MSB-first while the quotient shifts in at the LSB,
   // so after NUM_W steps num holds the quotient. The divisor is the frozen access_count.
   logic [NUM_W-1:0]    num;
   logic [CNT_W-1:0]    rem;
   logic [ITER_W-1:0]   iter;
   logic [CNT_W:0]      rem_shift;
   logic [CNT_W-1:0]    rem_sub;
   logic                q_bit;

   assign acc_inc     = access_count + CNT_W'(1);
   assign hit_inc     = hit_count + CNT_W'(hit);
   assign last_access = access_valid && (acc_inc == LIMIT_C);

   // rem < divisor < 2^CNT_W, so the shifted remainder fits CNT_W+1 bits and, when the
   // subtraction is taken, the difference fits CNT_W bits (modular subtract is exact).
   assign rem_shift = {rem, num[NUM_W-1]};
   assign q_bit     = (rem_shift >= {1'b0, access_count});
   assign rem_sub   = rem_shift[CNT_W-1:0] - access_count;

   assign window_done = (state != COUNT);
   assign busy        = (state == DIVIDE);
   assign rate_valid  = (state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COUNT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COUNT:   if (last_access) state_nxt = DIVIDE;
         DIVIDE:  if (iter == LAST_ITER) state_nxt = HOLD;
         HOLD:    if (rate_ready) state_nxt = COUNT;
         default: state_nxt = COUNT;
      endcase
      if (start) state_nxt = COUNT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         access_count  <= '0;
         hit_count     <= '0;
         num           <= '0;
         rem           <= '0;
         iter          <= '0;
         rate_permille <= '0;
      end else if (start) begin
         access_count  <= '0;
         hit_count     <= '0;
         num           <= '0;
         rem           <= '0;
         iter          <= '0;
         rate_permille <= '0;
      end else begin
         case (state)
            COUNT: begin
               if (access_valid) begin
                  access_count <= acc_inc;
                  hit_count    <= hit_inc;
                  if (last_access) begin
                     // Dividend includes the hit of the access that closes the window.
                     num  <= NUM_W'(hit_inc) * SCALE_N;
                     rem  <= '0;
                     iter <= '0;
                  end
               end
            end
            DIVIDE: begin
               num  <= {num[NUM_W-2:0], q_bit};
               rem  <= q_bit ? rem_sub : rem_shift[CNT_W-1:0];
               iter <= iter + ITER_W'(1);
               // Quotient never exceeds SCALE, so only the low 10 bits matter.
               if (iter == LAST_ITER) rate_permille <= {num[8:0], q_bit};
            end
            HOLD: begin
               if (rate_ready) begin
                  access_count <= '0;
                  hit_count    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_STATS_MISS_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  miss_count <= '0;
      else if (start)                              miss_count <= '0;
      else if (state == COUNT && access_valid)     miss_count <= miss_count + CNT_W'(!hit);
      else if (state == HOLD && rate_ready)        miss_count <= '0;
   end
`endif

endmodule

// File: tb/tb_cache_stats.sv
// Bench for cache_stats: three instances (ACCESS_LIMIT 8, 3, default 8192) share one input stream.
// A window-level model (counts, countdown, integer division) predicts every output each cycle.
// Directed scenarios pin the model with hand-computed literals; a randomized phase follows.

module tb_cache_stats;

   logic clk          = 1'b0;
   logic rst_n        = 1'b0;
   logic start        = 1'b0;
   logic access_valid = 1'b0;
   logic hit          = 1'b0;
   logic rate_ready   = 1'b0;
   logic chk_en       = 1'b0;

   always #5 clk = ~clk;

   logic [3:0]  a8_acc, a8_hit, a8_miss;
   logic [1:0]  a3_acc, a3_hit, a3_miss;
   logic [13:0] ad_acc, ad_hit, ad_miss;
   logic        a8_wd, a8_busy, a8_rv, a3_wd, a3_busy, a3_rv, ad_wd, ad_busy, ad_rv;
   logic [9:0]  a8_rate, a3_rate, ad_rate;

`ifndef CACHE_STATS_MISS_CNT_EN
   assign a8_miss = '0;
   assign a3_miss = '0;
   assign ad_miss = '0;
`endif

   cache_stats #(.ACCESS_LIMIT(8)) u_l8 (
      .clk(clk), .rst_n(rst_n), .start(start), .access_valid(access_valid), .hit(hit),
      .access_count(a8_acc), .hit_count(a8_hit),
`ifdef CACHE_STATS_MISS_CNT_EN
      .miss_count(a8_miss),
`endif
      .window_done(a8_wd), .busy(a8_busy), .rate_valid(a8_rv), .rate_ready(rate_ready),
      .rate_permille(a8_rate));

   cache_stats #(.ACCESS_LIMIT(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .start(start), .access_valid(access_valid), .hit(hit),
      .access_count(a3_acc), .hit_count(a3_hit),
`ifdef CACHE_STATS_MISS_CNT_EN
      .miss_count(a3_miss),
`endif
      .window_done(a3_wd), .busy(a3_busy), .rate_valid(a3_rv), .rate_ready(rate_ready),
      .rate_permille(a3_rate));

   cache_stats u_def (
      .clk(clk), .rst_n(rst_n), .start(start), .access_valid(access_valid), .hit(hit),
      .access_count(ad_acc), .hit_count(ad_hit),
`ifdef CACHE_STATS_MISS_CNT_EN
      .miss_count(ad_miss),
`endif
      .window_done(ad_wd), .busy(ad_busy), .rate_valid(ad_rv), .rate_ready(rate_ready),
      .rate_permille(ad_rate));

   // Model: phase 0 = counting, 1 = dividing (countdown of divider steps), 2 = holding result.
   int lim [3] = '{8, 3, 8192};
   int nw  [3] = '{14, 12, 24};   // clog2(limit+1)+10
   int m_st[3], m_acc[3], m_hit[3], m_miss[3], m_left[3], m_q[3], m_rate[3];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            m_st[k] = 0; m_acc[k] = 0; m_hit[k] = 0; m_miss[k] = 0; m_left[k] = 0; m_rate[k] = 0;
         end else if (start) begin
            m_st[k] = 0; m_acc[k] = 0; m_hit[k] = 0; m_miss[k] = 0; m_left[k] = 0; m_rate[k] = 0;
         end else if (m_st[k] == 0) begin
            if (access_valid) begin
               m_acc[k]++;
               if (hit) m_hit[k]++;
               else     m_miss[k]++;
               if (m_acc[k] == lim[k]) begin
                  m_st[k]   = 1;
                  m_left[k] = nw[k];
                  m_q[k]    = (m_hit[k] * 1000) / m_acc[k];
               end
            end
         end else if (m_st[k] == 1) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_st[k]   = 2;
               m_rate[k] = m_q[k];
            end
         end else if (rate_ready) begin
            m_st[k] = 0; m_acc[k] = 0; m_hit[k] = 0; m_miss[k] = 0;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int k, input int acc, input int hc, input int mc,
                           input int wd, input int bsy, input int rv, input int rate);
      string t;
      t = $sformatf("lim%0d", lim[k]);
      cmp($sformatf("%s.access_count", t), acc, m_acc[k]);
      cmp($sformatf("%s.hit_count", t), hc, m_hit[k]);
      cmp($sformatf("%s.window_done", t), wd, int'(m_st[k] != 0));
      cmp($sformatf("%s.busy", t), bsy, int'(m_st[k] == 1));
      cmp($sformatf("%s.rate_valid", t), rv, int'(m_st[k] == 2));
      if (m_st[k] == 2) cmp($sformatf("%s.rate_permille", t), rate, m_rate[k]);
`ifdef CACHE_STATS_MISS_CNT_EN
      cmp($sformatf("%s.miss_count", t), mc, m_miss[k]);
      cmp($sformatf("%s.hit_plus_miss", t), hc + mc, acc);
`else
      if (mc != 0) cmp($sformatf("%s.miss_absent", t), mc, 0);
`endif
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, int'(a8_acc), int'(a8_hit), int'(a8_miss), int'(a8_wd), int'(a8_busy), int'(a8_rv), int'(a8_rate));
         cmp_inst(1, int'(a3_acc), int'(a3_hit), int'(a3_miss), int'(a3_wd), int'(a3_busy), int'(a3_rv), int'(a3_rate));
         cmp_inst(2, int'(ad_acc), int'(ad_hit), int'(ad_miss), int'(ad_wd), int'(ad_busy), int'(ad_rv), int'(ad_rate));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      access_valid = 1'b0;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   // Feed n back-to-back accesses, hit pattern taken LSB first.
   task automatic feed(input int n, input logic [31:0] pat);
      for (int i = 0; i < n; i++) begin
         access_valid = 1'b1;
         hit          = pat[i];
         tick();
      end
      access_valid = 1'b0;
      hit          = 1'b0;
   endtask

   initial begin
      int   n;
      logic seen;
      logic [7:0] pat8;

      tick();
      tick();
      chk_en = 1'b1;
      cmp("reset.access_count", int'(a8_acc), 0);
      cmp("reset.rate_valid", int'(a8_rv), 0);
      cmp("reset.rate_permille", int'(a8_rate), 0);
      rst_n = 1'b1;

      // Reset mid-count: outputs must clear between edges.
      feed(5, 32'h15);
      cmp("precount.access_count", int'(a8_acc), 5);
      cmp("precount.hit_count", int'(a8_hit), 3);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst.access_count", int'(a8_acc), 0);
      cmp("async_rst.hit_count", int'(a8_hit), 0);
      cmp("async_rst.window_done", int'(a8_wd), 0);
      tick();
      rst_n = 1'b1;

      // 6 of 8 hits, ready already high.
      pulse_start();
      rate_ready = 1'b1;
      pat8 = 8'b1101_1011;
      feed(8, 32'(pat8));
      cmp("w750.window_done", int'(a8_wd), 1);
      cmp("w750.busy", int'(a8_busy), 1);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (a8_rv) begin n = c; break; end
      end
      cmp("w750.latency", n, 14);
      cmp("w750.rate_permille", int'(a8_rate), 750);
      cmp("w750.hit_count", int'(a8_hit), 6);
      cmp("w750.access_count", int'(a8_acc), 8);
      tick();
      cmp("w750.cleared_count", int'(a8_acc), 0);
      cmp("w750.cleared_valid", int'(a8_rv), 0);
      rate_ready = 1'b0;

      // 1 of 8 hits, result held under backpressure with accesses offered.
      pulse_start();
      feed(8, 32'h1);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (a8_rv) begin n = c; break; end
      end
      cmp("w125.latency", n, 14);
      for (int c = 0; c < 20; c++) begin
         access_valid = 1'($urandom);
         hit          = 1'($urandom);
         tick();
         cmp("w125.rate_permille", int'(a8_rate), 125);
         cmp("w125.access_count", int'(a8_acc), 8);
         cmp("w125.rate_valid", int'(a8_rv), 1);
`ifdef CACHE_STATS_MISS_CNT_EN
         cmp("w125.miss_count", int'(a8_miss), 7);
`endif
      end
      access_valid = 1'b1;
      rate_ready   = 1'b1;
      tick();
      cmp("w125.handshake_count", int'(a8_acc), 0);
      cmp("w125.handshake_valid", int'(a8_rv), 0);
      access_valid = 1'b0;
      rate_ready   = 1'b0;

      // Limit 3, one hit: truncated third.
      pulse_start();
      feed(3, 32'h1);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (a3_rv) begin n = c; break; end
      end
      cmp("w333.latency", n, 12);
      cmp("w333.rate_permille", int'(a3_rate), 333);
      rate_ready = 1'b1;
      tick();
      rate_ready = 1'b0;
      feed(3, 32'h3);
      for (int c = 0; c < 5; c++) tick();
      cmp("abort.busy_before", int'(a3_busy), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      cmp("abort.busy", int'(a3_busy), 0);
      cmp("abort.window_done", int'(a3_wd), 0);
      cmp("abort.access_count", int'(a3_acc), 0);
      cmp("abort.rate_permille", int'(a3_rate), 0);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (a3_rv) seen = 1'b1;
      end
      cmp("abort.no_rate_valid", int'(seen), 0);

      // Default limit, every access a hit.
      pulse_start();
      access_valid = 1'b1;
      hit          = 1'b1;
      for (int c = 0; c < 8192; c++) tick();
      access_valid = 1'b0;
      hit          = 1'b0;
      cmp("full.window_done", int'(ad_wd), 1);
      n = 0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (ad_rv) begin n = c; break; end
      end
      cmp("full.latency", n, 24);
      cmp("full.rate_permille", int'(ad_rate), 1000);
      cmp("full.access_count", int'(ad_acc), 8192);
      cmp("full.hit_count", int'(ad_hit), 8192);
      rate_ready = 1'b1;
      tick();
      rate_ready = 1'b0;
      cmp("full.cleared", int'(ad_acc), 0);

      // Randomized traffic with occasional start and asynchronous reset.
      for (int c = 0; c < 4000; c++) begin
         start        = ($urandom_range(149) == 0);
         access_valid = ($urandom_range(3) != 0);
         hit          = 1'($urandom);
         rate_ready   = ($urandom_range(2) == 0);
         if ($urandom_range(699) == 0) begin
            #2 rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end

      start        = 1'b0;
      access_valid = 1'b0;
      tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
